io_bridge: RTL

IO_BRIDGE -- requirements
Module: io_bridge

---
 rtl/io_bridge.sv | 132 +++++++++++++
 1 files changed

// File: rtl/io_bridge.sv
// CPU-side bridge that stalls accesses to the slow I/O page and runs a
// request/acknowledge handshake with timeout; all other addresses pass through to RAM.
module io_bridge #(
   parameter logic [3:0] IO_PAGE = 4'hD,
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        RST,
   input  logic [15:0] AB,
   input  logic        WE,
   input  logic [7:0]  DO,
   input  logic [7:0]  RAM_DI,
   output logic [7:0]  DI,
   output logic        RDY,
   output logic        io_req,
   output logic        io_we,
   output logic [11:0] io_addr,
   output logic [7:0]  io_wdata,
   input  logic        io_ack,
   input  logic [7:0]  io_rdata,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        io_req_q, io_req_d;
   logic        io_we_q, io_we_d;
   logic [11:0] io_addr_q, io_addr_d;
   logic [7:0]  io_wdata_q, io_wdata_d;
   logic [7:0]  io_data_q, io_data_d;
   logic        sel_io_q, sel_io_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        bus_err_q, bus_err_d;
   logic        io_sel_s;
   logic        rdy_s;

   assign io_sel_s = (AB[15:12] == IO_PAGE);

   always_comb begin
      state_d    = state_q;
      io_req_d   = io_req_q;
      io_we_d    = io_we_q;
      io_addr_d  = io_addr_q;
      io_wdata_d = io_wdata_q;
      io_data_d  = io_data_q;
      sel_io_d   = sel_io_q;
      cnt_d      = cnt_q;
      bus_err_d  = bus_err_q;
      rdy_s      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rdy_s = !io_sel_s;
            if (io_sel_s) begin
               state_d    = ST_REQ;
               io_addr_d  = AB[11:0];
               io_we_d    = WE;
               io_wdata_d = DO;
               io_req_d   = 1'b1;
               cnt_d      = 8'd0;
            end else begin
               sel_io_d = 1'b0;
            end
         end
         ST_REQ: begin
            cnt_d = cnt_q + 8'd1;
            // An acknowledge arriving on the last allowed cycle still beats the timeout.
            if (io_ack) begin
               if (!io_we_q) begin
                  io_data_d = io_rdata;
               end else begin
                  io_data_d = io_data_q;
               end
               io_req_d = 1'b0;
               state_d  = ST_DONE;
            end else if (cnt_q == (TIMEOUT - 8'd1)) begin
               io_data_d = 8'hFF;
               bus_err_d = 1'b1;
               io_req_d  = 1'b0;
               state_d   = ST_DONE;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_DONE: begin
            rdy_s    = 1'b1;
            sel_io_d = 1'b1;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         io_req_q   <= 1'b0;
         io_we_q    <= 1'b0;
         io_addr_q  <= 12'h000;
         io_wdata_q <= 8'h00;
         io_data_q  <= 8'h00;
         sel_io_q   <= 1'b0;
         cnt_q      <= 8'd0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         io_req_q   <= io_req_d;
         io_we_q    <= io_we_d;
         io_addr_q  <= io_addr_d;
         io_wdata_q <= io_wdata_d;
         io_data_q  <= io_data_d;
         sel_io_q   <= sel_io_d;
         cnt_q      <= cnt_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign RDY      = rdy_s;
   assign DI       = sel_io_q ? io_data_q : RAM_DI;
   assign io_req   = io_req_q;
   assign io_we    = io_we_q;
   assign io_addr  = io_addr_q;
   assign io_wdata = io_wdata_q;
   assign bus_err  = bus_err_q;

endmodule
